// File: rtl/aurora_rx_nfc_buf.sv
// aurora_rx_nfc_buf
// -----------------------------------------------------------------------------
// Receive-side buffer between the Aurora 64b66b RX AXI-stream (which has no
// ready) and the router Q interface. Every RX word is absorbed into a local
// FIFO and drained to Q under router backpressure. FIFO occupancy drives the
// native flow control (NFC) requests: XOFF when the FIFO fills past XOFF_TH,
// and XON once it has drained to XON_TH. Single clock domain (Aurora user
// clock).
//
// Optional feature macro: AURORA_RX_LAST_EN
//   Defined   : FIFO is 65 bits wide, RX_TLAST is stored with each word and
//               is presented on the extra output Q_LAST alongside Q.
//   Undefined : RX_TLAST is ignored and Q_LAST does not exist.
//
// Ports
//   CLK         in   Aurora user clock
//   RST         in   asynchronous active-high reset
//   CH_UP       in   Aurora channel_up; low forces the NFC FSM back to RUN
//   RX_TDATA    in   64-bit RX data
//   RX_TVALID   in   RX valid (no ready exists)
//   RX_TLAST    in   RX last (used only with AURORA_RX_LAST_EN)
//   NFC_TVALID  out  NFC request valid
//   NFC_TDATA   out  NFC request word (XOFF / XON)
//   NFC_TREADY  in   NFC request accepted by the core
//   Q           out  64-bit data to router (holds last value when idle)
//   Q_VALID     out  Q carries a new word this cycle
//   Q_BP        in   router backpressure; a pop happens in cycles where it is 0
//   OVF         out  sticky overflow: an RX word arrived while full
//   LEVEL       out  registered FIFO occupancy, 0 .. 2^DEPTH_LOG2
//   Q_LAST      out  (AURORA_RX_LAST_EN only) TLAST of the word on Q
// -----------------------------------------------------------------------------
module aurora_rx_nfc_buf #(
  parameter int          DEPTH_LOG2    = 9,
  parameter int          XOFF_TH       = 384,
  parameter int          XON_TH        = 128,
  parameter logic [15:0] NFC_XOFF_WORD = 16'h0100,
  parameter logic [15:0] NFC_XON_WORD  = 16'h0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CH_UP,
  input  logic [63:0]           RX_TDATA,
  input  logic                  RX_TVALID,
  input  logic                  RX_TLAST,
  output logic                  NFC_TVALID,
  output logic [15:0]           NFC_TDATA,
  input  logic                  NFC_TREADY,
  output logic [63:0]           Q,
  output logic                  Q_VALID,
  input  logic                  Q_BP,
  output logic                  OVF,
  output logic [DEPTH_LOG2:0]   LEVEL
`ifdef AURORA_RX_LAST_EN
  ,
  output logic                  Q_LAST
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef AURORA_RX_LAST_EN
  localparam int WIDTH = 65;
`else
  localparam int WIDTH = 64;
`endif

  localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   XOFF_LVL = (DEPTH_LOG2 + 1)'(XOFF_TH);
  localparam logic [DEPTH_LOG2:0]   XON_LVL  = (DEPTH_LOG2 + 1)'(XON_TH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    RUN,
    SEND_XOFF,
    PAUSED,
    SEND_XON
  } nfc_state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [WIDTH-1:0]      wr_data;
  logic [WIDTH-1:0]      rd_data;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

`ifdef AURORA_RX_LAST_EN
  assign wr_data = {RX_TLAST, RX_TDATA};
`else
  assign wr_data = RX_TDATA;
`endif

  // Full/empty come from the registered LEVEL, so a word arriving while full
  // is dropped even if a pop happens in the same cycle.
  assign full    = (LEVEL == FULL_LVL);
  assign empty   = (LEVEL == '0);
  assign push    = RX_TVALID && !full;
  assign pop     = !Q_BP && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; clearing it would turn the RAM into
  // flops. Reset only needs to clear pointers and LEVEL to make it empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      LEVEL  <= '0;
      OVF    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   LEVEL <= LEVEL + LVL_ONE;
        2'b01:   LEVEL <= LEVEL - LVL_ONE;
        default: LEVEL <= LEVEL;
      endcase
      if (RX_TVALID && full) OVF <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Q output register: loaded on a pop, otherwise holds its last word
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q       <= '0;
      Q_VALID <= 1'b0;
`ifdef AURORA_RX_LAST_EN
      Q_LAST  <= 1'b0;
`endif
    end else begin
      Q_VALID <= pop;
      if (pop) begin
        Q <= rd_data[63:0];
`ifdef AURORA_RX_LAST_EN
        Q_LAST <= rd_data[64];
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // NFC FSM: Moore outputs decoded from the state register, so a raised
  // request stays stable until NFC_TREADY regardless of LEVEL.
  // ---------------------------------------------------------------------------
  nfc_state_t state;
  nfc_state_t state_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_nxt  = state;
    NFC_TVALID = 1'b0;
    NFC_TDATA  = NFC_XON_WORD;
    case (state)
      RUN: begin
        if (LEVEL >= XOFF_LVL) state_nxt = SEND_XOFF;
      end
      SEND_XOFF: begin
        NFC_TVALID = 1'b1;
        NFC_TDATA  = NFC_XOFF_WORD;
        if (NFC_TREADY) state_nxt = PAUSED;
      end
      PAUSED: begin
        if (LEVEL <= XON_LVL) state_nxt = SEND_XON;
      end
      SEND_XON: begin
        NFC_TVALID = 1'b1;
        NFC_TDATA  = NFC_XON_WORD;
        if (NFC_TREADY) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    // A dropped channel abandons any pending request; the FIFO is untouched.
    if (!CH_UP) state_nxt = RUN;
  end

endmodule

// File: tb/tb_aurora_rx_nfc_buf.sv
// Self-checking bench for aurora_rx_nfc_buf. A queue-based reference model
// updated on each rising edge predicts occupancy, overflow, the word stream on
// Q and the pending NFC request; a monitor on the falling edge compares the
// DUT against it and pops expected Q words from a scoreboard queue.
module tb_aurora_rx_nfc_buf;

  localparam int          DEPTH     = 512;
  localparam int          XOFF_TH   = 384;
  localparam int          XON_TH    = 128;
  localparam logic [15:0] XOFF_WORD = 16'h0100;
  localparam logic [15:0] XON_WORD  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_up = 1'b0;
  logic [63:0] rx_tdata = '0;
  logic        rx_tvalid = 1'b0;
  logic        rx_tlast = 1'b0;
  logic        nfc_tready = 1'b0;
  logic        q_bp = 1'b1;

  logic        nfc_tvalid;
  logic [15:0] nfc_tdata;
  logic [63:0] q;
  logic        q_valid;
  logic        ovf;
  logic [9:0]  level;
`ifdef AURORA_RX_LAST_EN
  logic        q_last;
`endif

  aurora_rx_nfc_buf dut (
    .CLK        (clk),
    .RST        (rst),
    .CH_UP      (ch_up),
    .RX_TDATA   (rx_tdata),
    .RX_TVALID  (rx_tvalid),
    .RX_TLAST   (rx_tlast),
    .NFC_TVALID (nfc_tvalid),
    .NFC_TDATA  (nfc_tdata),
    .NFC_TREADY (nfc_tready),
    .Q          (q),
    .Q_VALID    (q_valid),
    .Q_BP       (q_bp),
    .OVF        (ovf),
    .LEVEL      (level)
`ifdef AURORA_RX_LAST_EN
    ,
    .Q_LAST     (q_last)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the FIFO is a queue of {last, data}; a request is either
  // outstanding (XOFF or XON) or not, and the remote side is either paused or
  // running.
  // ---------------------------------------------------------------------------
  logic [64:0] m_fifo [$];
  logic [64:0] m_sb   [$];    // words expected to appear on Q, in order
  logic [64:0] m_q;           // expected Q contents (holds when idle)
  bit          m_qvalid;
  bit          m_ovf;
  bit          m_req;         // a request is outstanding
  bit          m_req_xoff;    // outstanding request is XOFF (else XON)
  bit          m_paused;      // remote has been told XOFF and not yet XON

  task automatic model_reset();
    m_fifo.delete();
    m_sb.delete();
    m_q      = '0;
    m_qvalid = 1'b0;
    m_ovf    = 1'b0;
    m_req    = 1'b0;
    m_req_xoff = 1'b0;
    m_paused = 1'b0;
  endtask

  task automatic model_step();
    int lvl;
    lvl = m_fifo.size();
    // Drain side: one word leaves when the router is not backpressuring.
    m_qvalid = (!q_bp && lvl > 0);
    if (m_qvalid) begin
      m_q = m_fifo.pop_front();
      m_sb.push_back(m_q);
    end
    // Fill side: occupancy before this edge decides whether there is room.
    if (rx_tvalid) begin
      if (lvl < DEPTH) m_fifo.push_back({rx_tlast, rx_tdata});
      else             m_ovf = 1'b1;
    end
    // Flow control decisions use the occupancy visible before this edge.
    if (!ch_up) begin
      m_req    = 1'b0;
      m_paused = 1'b0;
    end else if (m_req) begin
      if (nfc_tready) begin
        m_req    = 1'b0;
        m_paused = m_req_xoff;
      end
    end else if (!m_paused && lvl >= XOFF_TH) begin
      m_req      = 1'b1;
      m_req_xoff = 1'b1;
    end else if (m_paused && lvl <= XON_TH) begin
      m_req      = 1'b1;
      m_req_xoff = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    logic [64:0] w;
    forever begin
      @(negedge clk);
      check("level", 64'(level), 64'(m_fifo.size()));
      check("ovf", 64'(ovf), 64'(m_ovf));
      check("nfc_tvalid", 64'(nfc_tvalid), 64'(m_req));
      if (m_req)
        check("nfc_tdata", 64'(nfc_tdata), 64'(m_req_xoff ? XOFF_WORD : XON_WORD));
      check("q_valid", 64'(q_valid), 64'(m_qvalid));
      check("q_hold", q, m_q[63:0]);
      if (q_valid === 1'b1) begin
        if (m_sb.size() == 0) begin
          bad++;
          total++;
          $display("FAIL q_unexpected at %0t: got %h want none", $time, q);
        end else begin
          w = m_sb.pop_front();
          check("q_data", q, w[63:0]);
`ifdef AURORA_RX_LAST_EN
          check("q_last", 64'(q_last), 64'(w[64]));
`endif
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    rx_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    rx_tvalid = 1'b1;
    rx_tdata  = d;
    rx_tlast  = last;
    @(negedge clk);
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  task automatic reset_checks();
    check("rst_nfc_tvalid", 64'(nfc_tvalid), 64'd0);
    check("rst_nfc_tdata", 64'(nfc_tdata), 64'(XON_WORD));
    check("rst_q", q, 64'd0);
    check("rst_q_valid", 64'(q_valid), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_level", 64'(level), 64'd0);
`ifdef AURORA_RX_LAST_EN
    check("rst_q_last", 64'(q_last), 64'd0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_checks();
    rst   = 1'b0;
    ch_up = 1'b1;
    q_bp  = 1'b0;
    @(negedge clk);

    // Pass-through: words 0..15 back to back, TLAST on word 7.
    for (int i = 0; i < 16; i++) send(64'(i), i == 7);
    idle(6);

    // XOFF: fill to the threshold with the router stalled, hold the request.
    q_bp = 1'b1;
    nfc_tready = 1'b0;
    for (int i = 0; i < XOFF_TH; i++) send({$urandom, $urandom}, 1'b0);
    idle(6);
    nfc_tready = 1'b1;
    @(negedge clk);
    nfc_tready = 1'b0;
    idle(3);
    // Drain below XON threshold, acknowledging with random latency.
    q_bp = 1'b0;
    for (int i = 0; i < 420; i++) begin
      nfc_tready = 1'($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    nfc_tready = 1'b1;
    idle(4);

    // Overflow: 520 words into a stalled FIFO, then drain.
    q_bp = 1'b1;
    nfc_tready = 1'b0;
    for (int i = 0; i < 520; i++) send(64'(i), 1'b0);
    idle(4);
    q_bp = 1'b0;
    for (int i = 0; i < 540; i++) begin
      nfc_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end

    // Simultaneous push/pop at the XOFF threshold.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_bp = 1'b1;
    nfc_tready = 1'b0;
    for (int i = 0; i < XOFF_TH; i++) send({$urandom, $urandom}, 1'b0);
    q_bp = 1'b0;
    nfc_tready = 1'b1;
    for (int i = 0; i < 30; i++) send({$urandom, $urandom}, 1'b0);
    idle(420);

    // Channel drop while an XOFF is pending: FIFO keeps draining in order.
    q_bp = 1'b1;
    nfc_tready = 1'b0;
    for (int i = 0; i < 390; i++) send({$urandom, $urandom}, 1'($urandom));
    idle(3);
    ch_up = 1'b0;
    q_bp  = 1'b0;
    idle(10);
    ch_up = 1'b1;
    nfc_tready = 1'b1;
    idle(420);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ch_up      = 1'($urandom_range(0, 49) != 0);
      q_bp       = 1'($urandom_range(0, 99) < 55);
      nfc_tready = 1'($urandom_range(0, 3) == 0);
      rx_tvalid  = 1'($urandom_range(0, 9) < 6);
      rx_tdata   = {$urandom, $urandom};
      rx_tlast   = 1'($urandom);
      @(negedge clk);
    end
    rx_tvalid = 1'b0;

    // Reset mid-stream: outputs must clear without waiting for a clock edge.
    q_bp = 1'b0;
    for (int i = 0; i < 20; i++) send(64'(100 + i), 1'b0);
    rx_tvalid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    reset_checks();
    @(negedge clk);
    rx_tvalid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(64'(200 + i), i == 7);
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aurora_rx_nfc_buf.md
Name: aurora_rx_nfc_buf

Overview:
Receive-side counterpart to the router-to-Aurora transmit path. Aurora 64b66b RX AXI-stream has no backpressure, so this block absorbs every RX word into a local FIFO. It drains the FIFO to the router Q interface and throttles the remote transmitter with native flow control (NFC) XOFF/XON requests driven by FIFO occupancy. It sits between the Aurora core's m_axi_rx/s_axi_nfc ports and the router, and runs entirely in the Aurora user-clock domain.

Parameters:
DEPTH_LOG2, 9, log2 of FIFO depth in 64-bit words (512).
XOFF_TH, 384, occupancy at or above which XOFF is requested.
XON_TH, 128, occupancy at or below which XON is requested; XON_TH < XOFF_TH <= 2^DEPTH_LOG2.
NFC_XOFF_WORD, 16'h0100, NFC_TDATA value sent for XOFF.
NFC_XON_WORD, 16'h0000, NFC_TDATA value sent for XON.

Ports:
CLK  in  1  Aurora user clock; the only clock.
RST  in  1  reset, asynchronous, active-high.
CH_UP  in  1  Aurora channel_up.
RX_TDATA  in  64  Aurora RX data.
RX_TVALID  in  1  Aurora RX valid; no ready exists.
RX_TLAST  in  1  Aurora RX last.
NFC_TVALID  out  1  NFC request valid.
NFC_TDATA  out  16  NFC request word.
NFC_TREADY  in  1  NFC accepted by core.
Q  out  64  data to router.
Q_VALID  out  1  Q holds a word this cycle.
Q_BP  in  1  router backpressure.
OVF  out  1  sticky overflow flag.
LEVEL  out  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset values: NFC_TVALID=0, NFC_TDATA=NFC_XON_WORD, Q=0, Q_VALID=0, OVF=0, LEVEL=0; FIFO emptied; NFC FSM in RUN. Reset mid-operation discards all buffered words and any pending NFC request.
- Write: every cycle with RX_TVALID=1 and LEVEL < 2^DEPTH_LOG2, RX_TDATA is written. If RX_TVALID=1 while full, the word is dropped, OVF is set, and OVF stays set until RST.
- Read: in cycle t, if Q_BP=0 and the FIFO is non-empty, one word is popped. Q and Q_VALID=1 are registered at t+1. Otherwise Q_VALID=0 at t+1 and Q holds its last value.
- Q_BP is honoured with one cycle of lag. The router accepts every word presented with Q_VALID=1.
- Latency: an RX word written into an empty FIFO with Q_BP=0 appears on Q two cycles later.
- LEVEL is registered and counts stored words. Push and pop in the same cycle leave it unchanged. It is 2^DEPTH_LOG2 exactly when full; pointers wrap modulo depth.
- NFC FSM:
  - RUN: NFC_TVALID=0. If LEVEL >= XOFF_TH, go to SEND_XOFF.
  - SEND_XOFF: NFC_TVALID=1, NFC_TDATA=NFC_XOFF_WORD, both held stable until NFC_TREADY=1, then go to PAUSED.
  - PAUSED: NFC_TVALID=0. If LEVEL <= XON_TH, go to SEND_XON.
  - SEND_XON: NFC_TVALID=1, NFC_TDATA=NFC_XON_WORD, held until NFC_TREADY=1, then go to RUN.
  - Thresholds are evaluated on registered LEVEL. A request, once raised, is never withdrawn or changed while CH_UP=1, even if LEVEL recrosses.
- CH_UP=0: FSM forced to RUN and NFC_TVALID=0 in the next cycle. The FIFO keeps its contents and keeps draining. RX writes still occur if RX_TVALID is asserted.

Optional Feature:
Macro AURORA_RX_LAST_EN.
- Defined: the FIFO is 65 bits wide and stores RX_TLAST with each word. An extra output Q_LAST (1 bit, reset 0) is registered alongside Q and is valid when Q_VALID=1.
- Undefined: RX_TLAST is ignored, the FIFO is 64 bits wide, and no Q_LAST port exists.

Test Plan:
- Pass-through: reset, CH_UP=1, Q_BP=0; drive 16 RX words 0..15 on consecutive cycles -> Q delivers 0..15 in order, first word 2 cycles after its RX cycle, LEVEL never exceeds 2, NFC_TVALID stays 0.
- XOFF/XON: Q_BP=1, stream 384 words -> NFC_TVALID=1 with NFC_TDATA=16'h0100 the cycle after LEVEL reaches 384. Hold NFC_TREADY=0 for 5 cycles -> request stable. Pulse NFC_TREADY -> NFC_TVALID=0. Release Q_BP -> when LEVEL reaches 128, NFC_TDATA=16'h0000 is requested once.
- Overflow: Q_BP=1, 520 RX words -> LEVEL saturates at 512, OVF=1 and stays 1. Q_BP=0 -> exactly words 0..511 emerge.
- Simultaneous push/pop at LEVEL=384 with RX_TVALID=1 and Q_BP=0 each cycle -> LEVEL holds at 384 and a single XOFF is issued.
- Channel drop: while in SEND_XOFF, drop CH_UP -> NFC_TVALID=0 the next cycle, FIFO contents intact and drained in order. Assert RST mid-stream -> all outputs return to reset values immediately.
- AURORA_RX_LAST_EN: words 0..7 with TLAST on word 7 -> Q_LAST=1 only alongside Q=7.
